soc_system_pio_arbiter: RTL and testbench

Round-robin arbiter that lets `NUM_REQ` Avalon-MM masters share the single 8-bit PIO output slave, with a 2-bit address and combinational zero-latency readdata, in `soc_system`. It serialises requests, presents one registered transfer at a time to the slave, and returns completion to each requester with `waitrequest`. It sits between the requesting masters and the PIO slave port, inside the same clock domain.

---
 rtl/soc_system_pio_pkg.sv | 15 +
 rtl/soc_system_rr_picker.sv | 36 +++
 rtl/soc_system_pio_arbiter.sv | 143 ++++++++++++++
 tb/tb_soc_system_pio_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared types and constants for the soc_system PIO arbiter slice.
package soc_system_pio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam int PIO_ADDR_W = 2;
  localparam int PIO_DATA_W = 32;
  localparam int PIO_OUT_W  = 8;
  localparam int MAX_REQ    = 8;

endpackage

// File: rtl/soc_system_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr_i.
module soc_system_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/soc_system_pio_arbiter.sv
// Round-robin arbiter serialising NUM_REQ Avalon-MM masters
// onto the single PIO slave, one registered transfer at a time.
module soc_system_pio_arbiter
  import soc_system_pio_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = PIO_ADDR_W,
  parameter int DATA_W  = PIO_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_chipselect,
  input  logic [NUM_REQ-1:0]        req_write_n,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [ADDR_W-1:0]         avs_address,
  output logic                      avs_chipselect,
  output logic                      avs_write_n,
  output logic [DATA_W-1:0]         avs_writedata,
  input  logic [DATA_W-1:0]         avs_readdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               cs_q, cs_d;
  logic               wn_q, wn_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0] wait_q, wait_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_wn;

  soc_system_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req_chipselect),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // One-hot grant makes an AND-OR mux sufficient.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      sel_addr |= req_address[r*ADDR_W +: ADDR_W]
                & {ADDR_W{gnt[r]}};
      sel_data |= req_writedata[r*DATA_W +: DATA_W]
                & {DATA_W{gnt[r]}};
    end
  end

  assign sel_wn = |(gnt & req_write_n);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    cs_d    = cs_q;
    wn_d    = wn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wait_d  = '1;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          addr_d  = sel_addr;
          wdata_d = sel_data;
          wn_d    = sel_wn;
          cs_d    = 1'b1;
          win_d   = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wn_q) begin
          rdata_d = avs_readdata;
        end
        cs_d          = 1'b0;
        wn_d          = 1'b1;
        wait_d[win_q] = 1'b0;
        state_d       = DONE;
      end
      DONE: begin
        if (win_q == IDX_W'(NUM_REQ-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      wait_q  <= '1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
    end
  end

  assign avs_address     = addr_q;
  assign avs_chipselect  = cs_q;
  assign avs_write_n     = wn_q;
  assign avs_writedata   = wdata_q;
  assign req_readdata    = rdata_q;
  assign req_waitrequest = wait_q;

endmodule

// File: tb/tb_soc_system_pio_arbiter.sv
// Scoreboard bench for soc_system_pio_arbiter with a PIO slave model.
`timescale 1ns/1ps
module tb_soc_system_pio_arbiter;
  import soc_system_pio_pkg::*;

  localparam int N  = 3;
  localparam int AW = PIO_ADDR_W;
  localparam int DW = PIO_DATA_W;

  logic clk = 1'b0;
  logic reset_n;

  logic [N-1:0]    cs;
  logic [N-1:0]    wn;
  logic [AW-1:0]   addr [N];
  logic [DW-1:0]   wd   [N];
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_writedata;

  logic [DW-1:0] req_readdata;
  logic [N-1:0]  req_waitrequest;
  logic [AW-1:0] avs_address;
  logic          avs_chipselect;
  logic          avs_write_n;
  logic [DW-1:0] avs_writedata;
  logic [DW-1:0] avs_readdata;

  logic [PIO_OUT_W-1:0] out_port = '0;

  always_comb begin
    req_address   = '0;
    req_writedata = '0;
    for (int r = 0; r < N; r++) begin
      req_address[r*AW +: AW]   = addr[r];
      req_writedata[r*DW +: DW] = wd[r];
    end
  end

  soc_system_pio_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_chipselect  (cs),
    .req_write_n     (wn),
    .req_address     (req_address),
    .req_writedata   (req_writedata),
    .req_readdata    (req_readdata),
    .req_waitrequest (req_waitrequest),
    .avs_address     (avs_address),
    .avs_chipselect  (avs_chipselect),
    .avs_write_n     (avs_write_n),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata)
  );

  // PIO output slave: only address 0 holds an 8-bit register.
  always @(posedge clk)
    if (avs_chipselect && !avs_write_n && avs_address == '0)
      out_port <= avs_writedata[PIO_OUT_W-1:0];

  assign avs_readdata = (avs_address == '0)
                      ? {{(DW-PIO_OUT_W){1'b0}}, out_port} : '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            who;
    bit            rd;
    logic [AW-1:0] a;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdata;
    int            ecyc;
  } exp_t;

  exp_t sbq [$];

  int n_cmp = 0;
  int n_bad = 0;

  int             model_ptr = 0;
  logic [7:0]     model_pio = '0;
  logic [DW-1:0]  model_rd  = '0;
  int             exp_cs    = 0;
  int             cs_cnt    = 0;

  int             last_cs_cyc = -10;
  logic [AW-1:0]  last_a;
  logic           last_wn;
  logic [DW-1:0]  last_wd;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(logic [N-1:0] m, int p);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = m >> ((p + i) % N);
      if (t[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_op(int w, int ecyc);
    exp_t e;
    e.who  = w;
    e.rd   = wn[w];
    e.a    = addr[w];
    e.wdat = wd[w];
    if (e.rd) begin
      model_rd = (e.a == '0) ? DW'(model_pio) : '0;
    end else if (e.a == '0) begin
      model_pio = e.wdat[7:0];
    end
    e.rdata = model_rd;
    e.ecyc  = ecyc;
    sbq.push_back(e);
    exp_cs++;
    model_ptr = (w + 1) % N;
  endtask

  task automatic run_batch(logic [N-1:0] mask, bit drop);
    int c;
    int w;
    logic [N-1:0] m;
    logic [N-1:0] pending;
    @(posedge clk); #1;
    c = cyc;
    m = mask;
    for (int k = 0; m != '0; k++) begin
      w = pick(m, model_ptr);
      model_op(w, c + 2 + 3 * k);
      m &= ~(N'(1) << w);
    end
    cs      = mask;
    pending = mask;
    for (int t = 0; t < 3 * N + 6 && pending != '0; t++) begin
      @(posedge clk); #1;
      pending &= req_waitrequest;
      cs      &= req_waitrequest;
      if (drop && avs_chipselect) cs = '0;
    end
    cs = '0;
    check("batch_complete", 64'(pending), 64'(0));
  endtask

  task automatic run_fair();
    int c;
    int w;
    logic [N-1:0] m;
    @(posedge clk); #1;
    c = cyc;
    wn[0] = 1'b0; addr[0] = '0; wd[0] = 32'h33;
    wn[1] = 1'b0; addr[1] = '0; wd[1] = 32'h44;
    m = N'(3);
    for (int k = 0; k < 4; k++) begin
      w = pick(m, model_ptr);
      model_op(w, c + 2 + 3 * k);
    end
    cs = m;
    repeat (12) begin
      @(posedge clk); #1;
    end
    cs = '0;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_waitreq"}, 64'(req_waitrequest), 64'({N{1'b1}}));
    check({tag, "_avs_cs"}, 64'(avs_chipselect), 64'(0));
    check({tag, "_avs_wn"}, 64'(avs_write_n), 64'(1));
    check({tag, "_avs_addr"}, 64'(avs_address), 64'(0));
    check({tag, "_avs_wdata"}, 64'(avs_writedata), 64'(0));
    check({tag, "_readdata"}, 64'(req_readdata), 64'(0));
  endtask

  exp_t         mon_e;
  logic [N-1:0] mon_ew;

  always @(negedge clk) begin
    if (reset_n) begin
      if (avs_chipselect) begin
        cs_cnt++;
        last_cs_cyc = cyc;
        last_a      = avs_address;
        last_wn     = avs_write_n;
        last_wd     = avs_writedata;
      end
      if (req_waitrequest !== {N{1'b1}}) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 64'(req_waitrequest),
                64'({N{1'b1}}));
        end else begin
          mon_e  = sbq.pop_front();
          mon_ew = '1;
          mon_ew = mon_ew & ~(N'(1) << mon_e.who);
          check("done_who", 64'(req_waitrequest), 64'(mon_ew));
          check("done_cycle", 64'(cyc), 64'(mon_e.ecyc));
          check("cs_cycle", 64'(last_cs_cyc), 64'(cyc - 1));
          check("avs_write_n", 64'(last_wn), 64'(mon_e.rd));
          check("avs_address", 64'(last_a), 64'(mon_e.a));
          if (!mon_e.rd)
            check("avs_writedata", 64'(last_wd), 64'(mon_e.wdat));
          check("req_readdata", 64'(req_readdata), 64'(mon_e.rdata));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] mask;
    bit           drop;
    reset_n = 1'b0;
    cs = '0;
    wn = '1;
    for (int r = 0; r < N; r++) begin
      addr[r] = '0;
      wd[r]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset_n = 1'b1;

    // single write of 0xA5
    wn[0] = 1'b0; addr[0] = '0; wd[0] = 32'hA5;
    run_batch(N'(1), 1'b0);
    check("pio_after_write", 64'(out_port), 64'(8'hA5));

    // read-back, then read of an empty address
    wn[1] = 1'b1; addr[1] = '0;
    run_batch(N'(2), 1'b0);
    check("readback_a5", 64'(req_readdata), 64'(32'hA5));
    addr[1] = AW'(1);
    run_batch(N'(2), 1'b0);
    check("readback_addr1", 64'(req_readdata), 64'(0));

    // contention
    wn[0] = 1'b0; addr[0] = '0; wd[0] = 32'h11;
    wn[1] = 1'b0; addr[1] = '0; wd[1] = 32'h22;
    run_batch(N'(3), 1'b0);
    check("pio_contention", 64'(out_port), 64'(8'h22));

    run_fair();

    // reset during ISSUE of a read
    @(posedge clk); #1;
    wn[1] = 1'b1; addr[1] = '0;
    cs = N'(2);
    @(posedge clk); #1;
    check("pre_reset_cs", 64'(avs_chipselect), 64'(1));
    reset_n = 1'b0;
    cs = '0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    reset_n   = 1'b1;
    model_ptr = 0;
    model_rd  = '0;
    wn[2] = 1'b1; addr[2] = '0;
    run_batch(N'(6), 1'b0);

    // requester drops chipselect once granted
    wn[0] = 1'b0; addr[0] = '0; wd[0] = 32'h5A;
    run_batch(N'(1), 1'b1);
    check("pio_dropped_cs", 64'(out_port), 64'(8'h5A));

    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < N; r++) begin
        wn[r]   = 1'($urandom_range(0, 1));
        addr[r] = ($urandom_range(0, 1) == 0)
                ? '0 : AW'($urandom_range(1, 3));
        wd[r]   = $urandom;
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      drop = $onehot(mask) && ($urandom_range(0, 1) == 1);
      run_batch(mask, drop);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sbq.size()), 64'(0));
    check("slave_transfers", 64'(cs_cnt), 64'(exp_cs));
    check("pio_final", 64'(out_port), 64'(model_pio));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
